image_scan: RTL and testbench
=============================

# image_scan

Synthesizable raster source for the image pipeline: on a start pulse, it scans a frame memory row by row, two pixels per clock. It emits the hsync-qualified even/odd RGB888 stream that the bmp writer stage consumes. Line blanking is inserted between rows. An optional saturating brightness adjust can be compiled in ahead of the output registers.

## Interface
Parameters:
- WIDTH, 100, pixels per row; must be even.
- HEIGHT, 100, rows per frame.
- START_DELAY, 100, idle cycles between start and first row; ≥1.
- HBLANK, 160, cycles with hsync low between rows; ≥1.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- mem_rd  out  1  frame-memory read strobe.
- mem_addr  out  $clog2(WIDTH*HEIGHT/2)  pixel-pair index, row-major, top row first.
- mem_rdata  in  48  pair data, valid exactly 1 cycle after mem_rd. Bit fields: [23:16]/[15:8]/[7:0] = R0/G0/B0 (left pixel); [47:40]/[39:32]/[31:24] = R1/G1/B1.
- bright_val  in  8  brightness magnitude.
- bright_sub  in  1  1 = subtract, 0 = add.
- VSYNC  out  1  high while a frame is in progress.
- hsync  out  1  output pair valid.
- DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1  out  8 each  even (left) and odd (right) pixel.
- ctrl_done  out  1  one-cycle pulse after the last pair of the frame.

## Operation
- FSM states: IDLE, DELAY, ACTIVE, BLANK, FLUSH.
- IDLE:
  - start=1 → DELAY; delay counter cleared; VSYNC=1 from the next cycle.
  - start=0 → remain in IDLE.
- DELAY: counts START_DELAY cycles, then → ACTIVE.
- ACTIVE:
  - Asserts mem_rd every cycle for WIDTH/2 consecutive cycles; mem_addr increments by 1 each cycle.
  - Column counter wraps from WIDTH/2-1 to 0.
  - After the last pair of a row → BLANK, or → FLUSH if that row was HEIGHT-1.
- BLANK: HBLANK cycles with mem_rd=0, then → ACTIVE for the next row.
- FLUSH: waits 2 cycles to drain the read pipeline, then pulses ctrl_done, deasserts VSYNC, → IDLE.
- start outside IDLE is ignored.
- Data path:
  - The mem_rd strobe is delayed by two register stages to form hsync.
  - mem_rdata is registered one cycle after return and driven onto the DATA_* outputs on the same edge that raises hsync.
  - DATA_* hold their last value while hsync=0.
- Total hsync-high cycles per frame = WIDTH*HEIGHT/2, exactly.
- Reset (asynchronous, any time, including mid-frame):
  - FSM → IDLE; all counters → 0.
  - Outputs mem_rd, mem_addr, VSYNC, hsync, ctrl_done, DATA_* all → 0.
  - Pipeline contents are discarded; no partial frame resumes.

## Timing
- mem_rd for pair n at cycle t → hsync and data for pair n at cycle t+2.
- start at cycle 0 → first mem_rd at cycle START_DELAY+1 → first hsync at cycle START_DELAY+3.
- Row period = WIDTH/2 + HBLANK cycles; hsync is contiguous within a row.
- ctrl_done is asserted the cycle after the final hsync. VSYNC falls on the same edge that ctrl_done rises.
- The earliest accepted next start is the cycle after ctrl_done.

## Configuration
- PIXEL_BRIGHTNESS_EN defined:
  - Each of the 6 channels becomes sat(ch ± bright_val), clamped to [0,255].
  - The adjust is computed in 9-bit arithmetic.
  - bright_val and bright_sub are sampled on the same cycle as the mem_rdata they apply to.
  - Latency is unchanged (combinational, before the output register).
- PIXEL_BRIGHTNESS_EN undefined:
  - Channels pass through unmodified.
  - bright_val and bright_sub remain as ports but are ignored.

## Structure
- Shared package img_pkg holds:
  - the scan-state enum (IDLE, DELAY, ACTIVE, BLANK, FLUSH);
  - an RGB888 pixel struct and a pixel-pair struct matching the mem_rdata layout;
  - constant BMP_BPP = 24.
- Sub-module pixel_sat_add: one 8-bit channel, ±magnitude with saturation. Instantiated 6 times under PIXEL_BRIGHTNESS_EN.

## Test plan
Default parameter set for these tests: WIDTH=4, HEIGHT=2, START_DELAY=3, HBLANK=2. Memory model has 1-cycle latency and holds pair k = {24'(2k+1), 24'(2k)}.
- Frame timing:
  - Stimulus: start pulse at cycle 0.
  - Expected: first mem_rd at cycle 4; hsync high at cycles 6–7 and 10–11 (4 pairs in total).
  - Expected: ctrl_done at cycle 12; VSYNC high over cycles 1–11.
- Addressing and data:
  - Expected: mem_addr sequence 0,1,2,3.
  - Expected: pair 2 yields DATA_B0=4 and DATA_B1=5, with R and G equal to 0.
- Ignored start:
  - Stimulus: start re-pulsed at cycle 7.
  - Expected: no effect.
  - Stimulus: start at cycle 13.
  - Expected: a second frame with identical timing.
- Reset mid-operation:
  - Stimulus: HRESETn low at cycle 7, released at cycle 9.
  - Expected: all outputs 0 immediately and no further hsync until a new start.
- Brightness (PIXEL_BRIGHTNESS_EN defined), bright_val=10:
  - Stimulus: channel 250 with bright_sub=0.
  - Expected: 255.
  - Stimulus: channel 4 with bright_sub=1.
  - Expected: 0.
  - Stimulus: channel 100 with bright_sub=0.
  - Expected: 110.
- Pass-through (PIXEL_BRIGHTNESS_EN undefined):
  - Stimulus: bright_val=10 on the brightness stimulus above.
  - Expected: channels equal to memory contents.
- Full-size run (default parameters, 100×100):
  - Expected: exactly 5000 hsync cycles, then one ctrl_done.

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and constants for the image scan pipeline: scan states and RGB888 pixel/pair layouts.
package img_pkg;

    localparam int unsigned BMP_BPP = 24;
    localparam int unsigned CH_W    = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        ACTIVE = 3'd2,
        BLANK  = 3'd3,
        FLUSH  = 3'd4
    } scan_state_e;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb888_t;

    // p0 (left/even pixel) occupies the low 24 bits of the memory word
    typedef struct packed {
        rgb888_t p1;
        rgb888_t p0;
    } pix_pair_t;

endpackage

// File: rtl/pixel_sat_add.sv
// One 8-bit colour channel plus or minus a magnitude, saturated to [0,255] via 9-bit arithmetic.
module pixel_sat_add
    import img_pkg::*;
(
    input  logic [CH_W-1:0] i_ch,
    input  logic [CH_W-1:0] i_mag,
    input  logic            i_sub,
    output logic [CH_W-1:0] o_ch_c
);

    logic [CH_W:0] w_sum;

    // Bit 8 flags overflow on add and borrow on subtract
    always_comb begin
        w_sum  = '0;
        o_ch_c = '0;
        if (i_sub) begin
            w_sum = {1'b0, i_ch} - {1'b0, i_mag};
        end else begin
            w_sum = {1'b0, i_ch} + {1'b0, i_mag};
        end
        if (!w_sum[CH_W]) begin
            o_ch_c = w_sum[CH_W-1:0];
        end else if (i_sub) begin
            o_ch_c = '0;
        end else begin
            o_ch_c = '1;
        end
    end

endmodule

// File: rtl/image_scan.sv
// Raster source: scans frame memory two pixels per clock with line blanking and emits an hsync-qualified RGB888 pair stream.
// Optional saturating brightness adjust compiled in with PIXEL_BRIGHTNESS_EN.
module image_scan
    import img_pkg::*;
#(
    parameter int unsigned WIDTH       = 100,
    parameter int unsigned HEIGHT      = 100,
    parameter int unsigned START_DELAY = 100,
    parameter int unsigned HBLANK      = 160
) (
    input  logic                                 HCLK,
    input  logic                                 HRESETn,
    input  logic                                 start,
    output logic                                 mem_rd,
    output logic [$clog2(WIDTH*HEIGHT/2)-1:0]    mem_addr,
    input  logic [47:0]                          mem_rdata,
    input  logic [7:0]                           bright_val,
    input  logic                                 bright_sub,
    output logic                                 VSYNC,
    output logic                                 hsync,
    output logic [7:0]                           DATA_R0,
    output logic [7:0]                           DATA_G0,
    output logic [7:0]                           DATA_B0,
    output logic [7:0]                           DATA_R1,
    output logic [7:0]                           DATA_G1,
    output logic [7:0]                           DATA_B1,
    output logic                                 ctrl_done
);

    localparam int unsigned PAIRS   = WIDTH / 2;
    localparam int unsigned AW      = $clog2(WIDTH * HEIGHT / 2);
    localparam int unsigned COL_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int unsigned ROW_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned CNT_MAX = (START_DELAY > HBLANK) ?
                                      ((START_DELAY > 2) ? START_DELAY : 2) :
                                      ((HBLANK > 2) ? HBLANK : 2);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    scan_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt;
    logic [ROW_W-1:0] r_row, w_row_nxt;
    logic [AW-1:0]    r_addr, w_addr_nxt;
    logic             w_done_nxt;

    logic             r_mem_rd, r_rd_d1, r_hsync, r_vsync, r_done;
    pix_pair_t        r_data;
    pix_pair_t        w_rdata, w_adj;

    // Next-state and counter logic; a start during the done pulse is not yet accepted
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_addr_nxt  = r_addr;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start && !r_done) begin
                    w_state_nxt = DELAY;
                    w_cnt_nxt   = '0;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_addr_nxt  = '0;
                end
            end
            DELAY: begin
                if (r_cnt == CNT_W'(START_DELAY - 1)) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ACTIVE: begin
                w_addr_nxt = r_addr + AW'(1);
                if (r_col == COL_W'(PAIRS - 1)) begin
                    w_col_nxt = '0;
                    w_cnt_nxt = '0;
                    if (r_row == ROW_W'(HEIGHT - 1)) begin
                        w_state_nxt = FLUSH;
                    end else begin
                        w_state_nxt = BLANK;
                        w_row_nxt   = r_row + ROW_W'(1);
                    end
                end else begin
                    w_col_nxt = r_col + COL_W'(1);
                end
            end
            BLANK: begin
                if (r_cnt == CNT_W'(HBLANK - 1)) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            FLUSH: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and control outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_addr   <= '0;
            r_mem_rd <= 1'b0;
            r_vsync  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_col    <= w_col_nxt;
            r_row    <= w_row_nxt;
            r_addr   <= w_addr_nxt;
            r_mem_rd <= (w_state_nxt == ACTIVE);
            r_vsync  <= (w_state_nxt != IDLE);
            r_done   <= w_done_nxt;
        end
    end

    assign w_rdata = pix_pair_t'(mem_rdata);

`ifdef PIXEL_BRIGHTNESS_EN
    pixel_sat_add u_sat_r0 (.i_ch(w_rdata.p0.r), .i_mag(bright_val), .i_sub(bright_sub), .o_ch_c(w_adj.p0.r));
    pixel_sat_add u_sat_g0 (.i_ch(w_rdata.p0.g), .i_mag(bright_val), .i_sub(bright_sub), .o_ch_c(w_adj.p0.g));
    pixel_sat_add u_sat_b0 (.i_ch(w_rdata.p0.b), .i_mag(bright_val), .i_sub(bright_sub), .o_ch_c(w_adj.p0.b));
    pixel_sat_add u_sat_r1 (.i_ch(w_rdata.p1.r), .i_mag(bright_val), .i_sub(bright_sub), .o_ch_c(w_adj.p1.r));
    pixel_sat_add u_sat_g1 (.i_ch(w_rdata.p1.g), .i_mag(bright_val), .i_sub(bright_sub), .o_ch_c(w_adj.p1.g));
    pixel_sat_add u_sat_b1 (.i_ch(w_rdata.p1.b), .i_mag(bright_val), .i_sub(bright_sub), .o_ch_c(w_adj.p1.b));
`else
    logic w_unused_bright;
    assign w_unused_bright = ^{bright_val, bright_sub};
    assign w_adj           = w_rdata;
`endif

    // Two-stage read-strobe delay; data captured alongside the second stage and held otherwise
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rd_d1 <= 1'b0;
            r_hsync <= 1'b0;
            r_data  <= '0;
        end else begin
            r_rd_d1 <= r_mem_rd;
            r_hsync <= r_rd_d1;
            if (r_rd_d1) begin
                r_data <= w_adj;
            end
        end
    end

    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_addr;
    assign VSYNC     = r_vsync;
    assign hsync     = r_hsync;
    assign ctrl_done = r_done;
    assign DATA_R0   = r_data.p0.r;
    assign DATA_G0   = r_data.p0.g;
    assign DATA_B0   = r_data.p0.b;
    assign DATA_R1   = r_data.p1.r;
    assign DATA_G1   = r_data.p1.g;
    assign DATA_B1   = r_data.p1.b;

endmodule

// File: tb/tb_image_scan.sv
// Directed bench for image_scan: small-frame timing, addressing, data, ignored start, mid-frame reset, brightness and a full-size run.
module tb_image_scan;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start, start_f;
    logic        mem_rd, mem_rd_f;
    logic [1:0]  mem_addr;
    logic [12:0] mem_addr_f;
    logic [47:0] mem_rdata;
    logic [47:0] mem_rdata_f;
    logic [7:0]  bright_val;
    logic        bright_sub;
    logic        VSYNC, hsync, ctrl_done;
    logic        vsync_f, hsync_f, done_f;
    logic [7:0]  DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
    logic [7:0]  f_r0, f_g0, f_b0, f_r1, f_g1, f_b1;
    logic [47:0] w_data;
    logic        ovr_en;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [47:0] OVR     = {8'd0,  8'd255, 8'd128, 8'd250, 8'd4,  8'd100};
`ifdef PIXEL_BRIGHTNESS_EN
    localparam logic [47:0] EXP_ADD = {8'd10, 8'd255, 8'd138, 8'd255, 8'd14, 8'd110};
    localparam logic [47:0] EXP_SUB = {8'd0,  8'd245, 8'd118, 8'd240, 8'd0,  8'd90};
`else
    localparam logic [47:0] EXP_ADD = OVR;
    localparam logic [47:0] EXP_SUB = OVR;
`endif

    always #5 HCLK = ~HCLK;

    image_scan #(.WIDTH(4), .HEIGHT(2), .START_DELAY(3), .HBLANK(2)) u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .bright_val(bright_val), .bright_sub(bright_sub),
        .VSYNC(VSYNC), .hsync(hsync),
        .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
        .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
        .ctrl_done(ctrl_done)
    );

    image_scan u_dut_full (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start_f),
        .mem_rd(mem_rd_f), .mem_addr(mem_addr_f), .mem_rdata(mem_rdata_f),
        .bright_val(bright_val), .bright_sub(bright_sub),
        .VSYNC(vsync_f), .hsync(hsync_f),
        .DATA_R0(f_r0), .DATA_G0(f_g0), .DATA_B0(f_b0),
        .DATA_R1(f_r1), .DATA_G1(f_g1), .DATA_B1(f_b1),
        .ctrl_done(done_f)
    );

    assign w_data = {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};

    function automatic logic [47:0] pair_val(input int k);
        return {24'(2 * k + 1), 24'(2 * k)};
    endfunction

    // One-cycle-latency frame memory; pair k holds {2k+1, 2k}
    always @(posedge HCLK) begin
        if (mem_rd) begin
            mem_rdata <= ovr_en ? OVR : pair_val(int'(mem_addr));
        end
        if (mem_rd_f) begin
            mem_rdata_f <= {35'd0, mem_addr_f};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_rd"},    64'(mem_rd),    64'd0);
        check({tag, " mem_addr"},  64'(mem_addr),  64'd0);
        check({tag, " vsync"},     64'(VSYNC),     64'd0);
        check({tag, " hsync"},     64'(hsync),     64'd0);
        check({tag, " ctrl_done"}, 64'(ctrl_done), 64'd0);
        check({tag, " data"},      64'(w_data),    64'd0);
    endtask

    // Called at a rising edge; that edge begins relative cycle 0, start is driven during cycle 0
    task automatic run_frame(input bit repulse, input bit ovr, input logic [47:0] exp_ovr);
        bit rd_exp, hs_exp;
        int pidx;
        for (int c = 0; c <= 12; c++) begin
            #1 start = (c == 0) || (repulse && c == 7);
            @(negedge HCLK);
            rd_exp = (c == 4) || (c == 5) || (c == 8) || (c == 9);
            hs_exp = (c == 6) || (c == 7) || (c == 10) || (c == 11);
            check($sformatf("vsync c%0d", c),     64'(VSYNC),     64'(c >= 1 && c <= 11));
            check($sformatf("mem_rd c%0d", c),    64'(mem_rd),    64'(rd_exp));
            check($sformatf("hsync c%0d", c),     64'(hsync),     64'(hs_exp));
            check($sformatf("ctrl_done c%0d", c), 64'(ctrl_done), 64'(c == 12));
            if (rd_exp) begin
                check($sformatf("mem_addr c%0d", c), 64'(mem_addr), 64'((c < 8) ? c - 4 : c - 6));
            end
            if (hs_exp || c == 8) begin
                pidx = (c < 8) ? c - 6 : ((c == 8) ? 1 : c - 8);
                check($sformatf("data c%0d", c), 64'(w_data), 64'(ovr ? exp_ovr : pair_val(pidx)));
            end
            @(posedge HCLK);
        end
        start = 1'b0;
    endtask

    initial begin
        int hs_cnt;
        int done_cnt;
        bit seen_done;
        HRESETn    = 1'b0;
        start      = 1'b0;
        start_f    = 1'b0;
        bright_val = 8'd10;
        bright_sub = 1'b0;
        ovr_en     = 1'b0;

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check_all_zero("reset");
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK);

        // First frame with a stray start at cycle 7, second frame starts at cycle 13
        run_frame(1'b1, 1'b0, 48'd0);
        run_frame(1'b0, 1'b0, 48'd0);

        ovr_en     = 1'b1;
        bright_sub = 1'b0;
        run_frame(1'b0, 1'b1, EXP_ADD);
        bright_sub = 1'b1;
        run_frame(1'b0, 1'b1, EXP_SUB);
        ovr_en     = 1'b0;
        bright_sub = 1'b0;

        // Reset asserted mid-frame at cycle 7, released at cycle 9
        #1 start = 1'b1;
        @(posedge HCLK);
        #1 start = 1'b0;
        repeat (6) @(posedge HCLK);
        #1 check("pre-reset hsync", 64'(hsync), 64'd1);
        HRESETn = 1'b0;
        #1 check_all_zero("mid-reset");
        @(posedge HCLK);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        hs_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge HCLK);
            if (hsync || VSYNC || mem_rd) hs_cnt++;
        end
        check("activity after reset", 64'(hs_cnt), 64'd0);
        @(posedge HCLK);
        run_frame(1'b0, 1'b0, 48'd0);

        // Full-size default-parameter frame
        #1 start_f = 1'b1;
        @(posedge HCLK);
        #1 start_f = 1'b0;
        hs_cnt    = 0;
        done_cnt  = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 30000 && !seen_done; i++) begin
            @(negedge HCLK);
            if (hsync_f) hs_cnt++;
            if (done_f) begin
                done_cnt++;
                seen_done = 1'b1;
            end
        end
        check("full frame finished", 64'(seen_done), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            if (hsync_f) hs_cnt++;
            if (done_f) done_cnt++;
        end
        check("full hsync count", 64'(hs_cnt), 64'd5000);
        check("full done count", 64'(done_cnt), 64'd1);
        check("full vsync low", 64'(vsync_f), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
